// File: rtl/mem_byte_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_ctrl_if
// Purpose  : Pipeline-side request and byte-wide memory bus of mem_byte_ctrl.
// Revision : 1.0
// ============================================================================
interface mem_byte_ctrl_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] alu_addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [7:0]  data_out [0:3];
    logic        hold;
    logic        mem_err;

    modport master (
        input  memread, memwrite, alu_addr, store_data, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, data_out, hold, mem_err
    );

    modport slave (
        output memread, memwrite, alu_addr, store_data, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, data_out, hold, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_byte_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_ctrl
// Purpose  : Sequences a word load/store as four byte transactions on a
//            variable-latency memory, freezing the pipeline while in flight.
// Revision : 1.0
// ============================================================================
module mem_byte_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mem_byte_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] c_WCNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_idx;
    logic [7:0]  r_wcnt;
    logic        r_op_we;
    logic        r_err;
    logic [7:0]  r_dout [0:3];
    logic        w_start;
    logic        w_ack;
    logic        w_timeout;
    logic [31:0] w_base;

    assign w_base       = bus.alu_addr & 32'hFFFF_FFFC;
    assign bus.data_out = r_dout;
    assign bus.mem_err  = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start       = 1'b0;
        w_ack         = 1'b0;
        w_timeout     = 1'b0;
        bus.hold      = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (bus.memread || bus.memwrite) begin
                    w_start  = 1'b1;
                    bus.hold = 1'b1;
                    w_next   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                bus.hold      = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = r_op_we;
                bus.mem_addr  = w_base + {30'd0, r_idx};
                bus.mem_wdata = bus.store_data[8*r_idx +: 8];
                if (bus.mem_ack) begin
                    w_ack = 1'b1;
                    if (r_idx == 2'd3) begin
                        w_next = S_DONE;
                    end
                end else if (r_wcnt == c_WCNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                // One hold-free cycle lets the finished instruction leave EX/MEM.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (rst) begin
            bus.hold = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= 2'd0;
            r_wcnt  <= 8'd0;
            r_op_we <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_dout[i] <= 8'h00;
            end
        end else begin
            if (w_start) begin
                r_op_we <= bus.memwrite;
                r_idx   <= 2'd0;
                r_wcnt  <= 8'd0;
            end
            if (w_ack) begin
                r_wcnt <= 8'd0;
                if (!r_op_we) begin
                    r_dout[r_idx] <= bus.mem_rdata;
                end
                if (r_idx != 2'd3) begin
                    r_idx <= r_idx + 2'd1;
                end
            end else if (r_state == S_ACCESS) begin
                r_wcnt <= r_wcnt + 8'd1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_byte_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_byte_ctrl
// Purpose  : Self-checking bench for mem_byte_ctrl with a word-level model.
// Revision : 1.0
// ============================================================================
module tb_mem_byte_ctrl;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    mem_byte_ctrl_if bus();

    mem_byte_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Word-level model: byte i of data_out lives in model_dout[8i+7:8i]
    logic [31:0] model_dout;
    logic        model_err;

    logic [31:0] obs_addr [0:3];
    logic [31:0] obs_wdata;
    logic [31:0] obs_dout;
    logic        obs_err;
    logic        obs_done_hold;
    logic        obs_first_hold;
    logic        obs_first_req;
    int          obs_n;
    int          obs_hold;
    int          obs_req;
    bit          obs_we_any;
    bit          obs_we_all;

    function automatic logic [31:0] dout_word();
        return {bus.data_out[3], bus.data_out[2], bus.data_out[1], bus.data_out[0]};
    endfunction

    // Drives one access as the pipeline and memory would, recording what the DUT shows.
    // waits < 0 means the memory never acknowledges. next_* are presented in DONE.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [31:0] rword,
                              input int waits, input bit tie_ack,
                              input bit next_rd, input bit next_wr,
                              input logic [31:0] next_addr, input logic [31:0] next_sdata);
        int  wc;
        bit  done;
        bus.memread    = rd;
        bus.memwrite   = wr;
        bus.alu_addr   = addr;
        bus.store_data = sdata;
        bus.mem_ack    = 1'b0;
        obs_n = 0; obs_hold = 0; obs_req = 0; obs_wdata = 32'h0;
        obs_we_any = 1'b0; obs_we_all = 1'b1;
        wc = 0; done = 1'b0;
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                obs_first_hold = bus.hold;
                obs_first_req  = bus.mem_req;
            end
            if (bus.hold) obs_hold++;
            if (bus.mem_req) begin
                obs_req++;
                obs_we_any = obs_we_any | bus.mem_we;
                obs_we_all = obs_we_all & bus.mem_we;
                if (waits >= 0 && wc == waits && obs_n < 4) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rword[8*obs_n +: 8];
                    obs_addr[obs_n] = bus.mem_addr;
                    obs_wdata[8*obs_n +: 8] = bus.mem_wdata;
                    obs_n++;
                    wc = 0;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 8'($urandom);
                    wc++;
                end
            end else begin
                bus.mem_ack   = tie_ack;
                bus.mem_rdata = 8'($urandom);
                if (obs_req > 0) begin
                    obs_done_hold  = bus.hold;
                    obs_dout       = dout_word();
                    obs_err        = bus.mem_err;
                    bus.memread    = next_rd;
                    bus.memwrite   = next_wr;
                    bus.alu_addr   = next_addr;
                    bus.store_data = next_sdata;
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.memread = 1'b1; bus.memwrite = 1'b0; bus.mem_ack = 1'b0;
        bus.alu_addr = 32'h0000_1234; bus.store_data = 32'h0; bus.mem_rdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.hold !== 1'b0) $display("FAIL reset_hold_forced: got %b expected 0", bus.hold); else n_pass++;
        #1 bus.memread = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        model_dout = 32'h0; model_err = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); else n_pass++;
        n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); else n_pass++;
        n_checks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); else n_pass++;
        n_checks++; if (bus.mem_wdata !== 8'h0) $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); else n_pass++;
        n_checks++; if (bus.hold !== 1'b0) $display("FAIL reset_hold: got %b expected 0", bus.hold); else n_pass++;
        n_checks++; if (bus.mem_err !== 1'b0) $display("FAIL reset_mem_err: got %b expected 0", bus.mem_err); else n_pass++;
        n_checks++; if (dout_word() !== model_dout) $display("FAIL reset_data_out: got %h expected %h", dout_word(), model_dout); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait_load;
        run_access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 32'hA3A2_A1A0, 0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        model_dout = 32'hA3A2_A1A0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (obs_addr[i] !== 32'h100 + 32'(i)) $display("FAIL zw_addr%0d: got %h expected %h", i, obs_addr[i], 32'h100 + 32'(i)); else n_pass++;
        end
        n_checks++; if (obs_hold !== 5) $display("FAIL zw_hold_cycles: got %0d expected 5", obs_hold); else n_pass++;
        n_checks++; if (obs_done_hold !== 1'b0) $display("FAIL zw_done_hold: got %b expected 0", obs_done_hold); else n_pass++;
        n_checks++; if (obs_we_any !== 1'b0) $display("FAIL zw_we: got %b expected 0", obs_we_any); else n_pass++;
        n_checks++; if (obs_dout !== model_dout) $display("FAIL zw_data_out: got %h expected %h", obs_dout, model_dout); else n_pass++;
        n_checks++; if (obs_req !== 4) $display("FAIL zw_req_cycles: got %0d expected 4", obs_req); else n_pass++;
    endtask

    task automatic test_store_wait;
        run_access(1'b0, 1'b1, 32'h0000_2008, 32'hDEAD_BEEF, 32'h5555_5555, 2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (obs_we_all !== 1'b1) $display("FAIL st_we: got %b expected 1", obs_we_all); else n_pass++;
        n_checks++; if (obs_wdata !== 32'hDEAD_BEEF) $display("FAIL st_wdata_seq: got %h expected deadbeef", obs_wdata); else n_pass++;
        n_checks++; if (obs_hold !== 13) $display("FAIL st_hold_cycles: got %0d expected 13", obs_hold); else n_pass++;
        n_checks++; if (obs_dout !== model_dout) $display("FAIL st_data_out: got %h expected %h", obs_dout, model_dout); else n_pass++;
        n_checks++; if (obs_addr[3] !== 32'h200B) $display("FAIL st_last_addr: got %h expected 200b", obs_addr[3]); else n_pass++;
    endtask

    task automatic test_both_requests;
        int k = int'($urandom_range(0, 3));
        run_access(1'b1, 1'b1, $urandom, $urandom, $urandom, k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (obs_we_all !== 1'b1) $display("FAIL both_we: got %b expected 1", obs_we_all); else n_pass++;
        n_checks++; if (obs_dout !== model_dout) $display("FAIL both_data_out: got %h expected %h", obs_dout, model_dout); else n_pass++;
        n_checks++; if (obs_hold !== 5 + 4*k) $display("FAIL both_hold_cycles: got %0d expected %0d", obs_hold, 5 + 4*k); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] a1 = $urandom, a2 = $urandom, sd = $urandom, rw = $urandom;
        run_access(1'b1, 1'b0, a1, 32'h0, rw, 0, 1'b0, 1'b0, 1'b1, a2, sd);
        model_dout = rw;
        n_checks++; if (obs_dout !== model_dout) $display("FAIL b2b_load_data: got %h expected %h", obs_dout, model_dout); else n_pass++;
        n_checks++; if (obs_done_hold !== 1'b0) $display("FAIL b2b_gap_hold: got %b expected 0", obs_done_hold); else n_pass++;
        run_access(1'b0, 1'b1, a2, sd, $urandom, 1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++; if ({obs_first_hold, obs_first_req} !== 2'b10) $display("FAIL b2b_idle_detect: got %b expected 10", {obs_first_hold, obs_first_req}); else n_pass++;
        n_checks++; if (obs_addr[0] !== {a2[31:2], 2'b00}) $display("FAIL b2b_first_addr: got %h expected %h", obs_addr[0], {a2[31:2], 2'b00}); else n_pass++;
        n_checks++; if (obs_wdata !== sd) $display("FAIL b2b_wdata_seq: got %h expected %h", obs_wdata, sd); else n_pass++;
        n_checks++; if (obs_hold !== 9) $display("FAIL b2b_hold_cycles: got %0d expected 9", obs_hold); else n_pass++;
        n_checks++; if (obs_dout !== model_dout) $display("FAIL b2b_store_data_out: got %h expected %h", obs_dout, model_dout); else n_pass++;
    endtask

    task automatic test_random;
        for (int t = 0; t < 20; t++) begin
            bit          wr = 1'($urandom);
            int          k  = int'($urandom_range(0, 3));
            logic [31:0] a = $urandom, sd = $urandom, rw = $urandom;
            logic [31:0] exp_base = {a[31:2], 2'b00};
            run_access(!wr, wr, a, sd, rw, k, 1'($urandom), 1'b0, 1'b0, 32'h0, 32'h0);
            if (!wr) model_dout = rw;
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (obs_addr[i] !== exp_base + 32'(i)) $display("FAIL rnd%0d_addr%0d: got %h expected %h", t, i, obs_addr[i], exp_base + 32'(i)); else n_pass++;
            end
            n_checks++; if (obs_hold !== 5 + 4*k) $display("FAIL rnd%0d_hold: got %0d expected %0d", t, obs_hold, 5 + 4*k); else n_pass++;
            n_checks++; if (obs_we_any !== wr || obs_we_all !== wr) $display("FAIL rnd%0d_we: got %b%b expected %b", t, obs_we_any, obs_we_all, wr); else n_pass++;
            n_checks++; if (obs_dout !== model_dout) $display("FAIL rnd%0d_data_out: got %h expected %h", t, obs_dout, model_dout); else n_pass++;
            if (wr) begin
                n_checks++; if (obs_wdata !== sd) $display("FAIL rnd%0d_wdata: got %h expected %h", t, obs_wdata, sd); else n_pass++;
            end
        end
    endtask

    task automatic test_ack_idle;
        bit any_req = 1'b0, any_hold = 1'b0;
        bus.memread = 1'b0; bus.memwrite = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = 8'($urandom);
            @(negedge clk);
            any_req  = any_req | bus.mem_req;
            any_hold = any_hold | bus.hold;
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
        @(negedge clk);
        n_checks++; if ({any_req, any_hold} !== 2'b00) $display("FAIL idle_ack_req_hold: got %b expected 00", {any_req, any_hold}); else n_pass++;
        n_checks++; if (dout_word() !== model_dout) $display("FAIL idle_ack_data_out: got %h expected %h", dout_word(), model_dout); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout;
        logic [31:0] rw = $urandom;
        run_access(1'b1, 1'b0, $urandom, 32'h0, $urandom, -1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_err = 1'b1;
        n_checks++; if (obs_req !== TO) $display("FAIL to_access_cycles: got %0d expected %0d", obs_req, TO); else n_pass++;
        n_checks++; if (obs_hold !== 1 + TO) $display("FAIL to_hold_cycles: got %0d expected %0d", obs_hold, 1 + TO); else n_pass++;
        n_checks++; if (obs_err !== model_err) $display("FAIL to_mem_err: got %b expected %b", obs_err, model_err); else n_pass++;
        n_checks++; if (obs_done_hold !== 1'b0) $display("FAIL to_done_hold: got %b expected 0", obs_done_hold); else n_pass++;
        n_checks++; if (obs_dout !== model_dout) $display("FAIL to_data_out: got %h expected %h", obs_dout, model_dout); else n_pass++;
        run_access(1'b1, 1'b0, $urandom, 32'h0, rw, 1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_dout = rw;
        n_checks++; if (obs_err !== model_err) $display("FAIL to_err_sticky: got %b expected %b", obs_err, model_err); else n_pass++;
        n_checks++; if (obs_dout !== model_dout) $display("FAIL to_next_load: got %h expected %h", obs_dout, model_dout); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int acks = 0;
        logic [31:0] rw = $urandom;
        bus.memread = 1'b1; bus.memwrite = 1'b0; bus.alu_addr = $urandom; bus.mem_ack = 1'b0;
        for (int c = 0; c < 50 && acks < 2; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = 8'($urandom_range(1, 255)); acks++;
            end else begin
                bus.mem_ack = 1'b0;
            end
            @(posedge clk); #1;
        end
        rst = 1'b1; bus.memread = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.hold !== 1'b0) $display("FAIL rmid_hold_in_reset: got %b expected 0", bus.hold); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        model_dout = 32'h0; model_err = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL rmid_mem_req: got %b expected 0", bus.mem_req); else n_pass++;
        n_checks++; if (bus.hold !== 1'b0) $display("FAIL rmid_hold: got %b expected 0", bus.hold); else n_pass++;
        n_checks++; if (dout_word() !== model_dout) $display("FAIL rmid_data_out: got %h expected %h", dout_word(), model_dout); else n_pass++;
        n_checks++; if (bus.mem_err !== model_err) $display("FAIL rmid_mem_err: got %b expected %b", bus.mem_err, model_err); else n_pass++;
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 32'h0000_4000, 32'h0, rw, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_dout = rw;
        n_checks++; if (obs_dout !== model_dout) $display("FAIL rmid_fresh_load: got %h expected %h", obs_dout, model_dout); else n_pass++;
        n_checks++; if (obs_hold !== 5) $display("FAIL rmid_fresh_hold: got %0d expected 5", obs_hold); else n_pass++;
        n_checks++; if (obs_addr[0] !== 32'h4000) $display("FAIL rmid_fresh_addr: got %h expected 4000", obs_addr[0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_wait();
        test_both_requests();
        test_back_to_back();
        test_random();
        test_ack_idle();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
